// File: rtl/fifo_axis_master_if.sv
// -----------------------------------------------------------------------------
// fifo_axis_master_if
//   Bundles the two handshake groups of the read-side stream stage:
//   the fifo-core read port and the AXI-Stream master port.
//
//   Signals
//     o_fifo_ren        read enable toward the core
//     i_fifo_rdata      core read data (valid a fixed latency after o_fifo_ren)
//     i_fifo_rempty     core empty flag, current-cycle pointer view
//     i_fifo_runderflow core underflow indication
//     o_m_axis_tvalid   stream word valid
//     o_m_axis_tdata    stream word
//     i_m_axis_tready   downstream ready
//
//   Modports
//     master  view taken by fifo_axis_master
//     slave   view taken by whatever sits on the other side (core + sink)
// -----------------------------------------------------------------------------
interface fifo_axis_master_if #(
    parameter int DLEN = 8
);
    logic            o_fifo_ren;
    logic [DLEN-1:0] i_fifo_rdata;
    logic            i_fifo_rempty;
    logic            i_fifo_runderflow;
    logic            o_m_axis_tvalid;
    logic [DLEN-1:0] o_m_axis_tdata;
    logic            i_m_axis_tready;

    modport master (
        output o_fifo_ren,
        input  i_fifo_rdata,
        input  i_fifo_rempty,
        input  i_fifo_runderflow,
        output o_m_axis_tvalid,
        output o_m_axis_tdata,
        input  i_m_axis_tready
    );

    modport slave (
        input  o_fifo_ren,
        output i_fifo_rdata,
        output i_fifo_rempty,
        output i_fifo_runderflow,
        input  o_m_axis_tvalid,
        input  o_m_axis_tdata,
        output i_m_axis_tready
    );
endinterface

// File: rtl/fifo_axis_master.sv
// -----------------------------------------------------------------------------
// fifo_axis_master
//   Read-side AXI-Stream master placed directly after the fifo core. It issues
//   read enables into the core, tracks each read through an RD_LAT-deep tag
//   shift register, and lands the returned word in a small circular queue whose
//   head is presented as the stream word. Reads are only issued when the queue
//   is guaranteed to have room for every word already in flight, so the queue
//   can never overflow and no word is lost or duplicated under any tready
//   pattern. With tready held high the stage streams one word per cycle.
//
//   Ports
//     clk              clock, rising edge
//     rst              asynchronous reset, active-high; release must be
//                      synchronous to clk (driven from a reset synchroniser)
//     bus              fifo_axis_master_if.master (core read port + AXIS master)
//     o_qcount         words currently held in the landing queue
//     o_err_underflow  sticky: core underflow seen, or read issued while empty
// -----------------------------------------------------------------------------
module fifo_axis_master #(
    parameter int DLEN   = 8,
    parameter int RD_LAT = 2,
    parameter int QDEPTH = RD_LAT + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    fifo_axis_master_if.master            bus,
    output logic [$clog2(QDEPTH+1)-1:0]   o_qcount,
    output logic                          o_err_underflow
);
    localparam int CW = $clog2(QDEPTH + 1);
    // Credit sum is qcount + inflight, which can reach 2*QDEPTH before the
    // pop is subtracted; size it so that intermediate never wraps.
    localparam int SW = $clog2(2 * QDEPTH + 1);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [RD_LAT-1:0] tag_sr;     // bit i set: a read issued i+1 cycles ago
    logic [SW-1:0]     inflight;
    logic [SW-1:0]     credit;
    logic              ren;
    logic              push;
    logic              pop;
    logic              tvalid;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic [DLEN-1:0]   mem [QDEPTH];

    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == AW'(QDEPTH - 1)) ? '0 : idx + AW'(1);
    endfunction

    // tvalid comes only from registered state, never from tready.
    assign tvalid = (o_qcount != '0);
    assign pop    = tvalid & bus.i_m_axis_tready;
    // The tag leaving the shift register marks the cycle the core's data is valid.
    assign push   = tag_sr[RD_LAT-1];

    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives the variable and no latch is inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SW'(tag_sr[i]);
        end
    end

    // Space still owed to words already queued or in flight; a popped word
    // frees its slot in the same cycle, which is what sustains full rate.
    assign credit = SW'(o_qcount) + inflight - SW'(pop);
    assign ren    = ~bus.i_fifo_rempty & (credit < SW'(QDEPTH));

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_sr          <= '0;
            rd_idx          <= '0;
            wr_idx          <= '0;
            o_qcount        <= '0;
            o_err_underflow <= 1'b0;
        end else begin
            tag_sr[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end

            if (push) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
            end

            case ({push, pop})
                2'b10:   o_qcount <= o_qcount + CW'(1);
                2'b01:   o_qcount <= o_qcount - CW'(1);
                default: o_qcount <= o_qcount;
            endcase

            if (bus.i_fifo_runderflow | (ren & bus.i_fifo_rempty)) begin
                o_err_underflow <= 1'b1;
            end
        end
    end

    // NOTE: the queue storage has no reset; validity is carried entirely by
    // o_qcount and the indices, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= bus.i_fifo_rdata;
        end
    end

    assign bus.o_fifo_ren      = ren;
    assign bus.o_m_axis_tvalid = tvalid;
    // Masking with tvalid keeps tdata at zero out of reset and while idle,
    // and it is still the unchanging head entry for as long as tvalid is held.
    assign bus.o_m_axis_tdata  = tvalid ? mem[rd_idx] : '0;

endmodule

// File: tb/tb_fifo_axis_master.sv
// -----------------------------------------------------------------------------
// tb_fifo_axis_master
//   Directed bench for fifo_axis_master (DLEN=8, RD_LAT=2, QDEPTH=3).
//   A small core model (word queue + two-stage read pipeline) feeds the DUT.
//   Inputs change 1 time unit after the rising edge; DUT outputs are sampled
//   1 time unit before the next rising edge, so each sample describes one
//   whole clock cycle including the handshake seen by that edge.
// -----------------------------------------------------------------------------
module tb_fifo_axis_master;
    localparam int DLEN   = 8;
    localparam int RD_LAT = 2;
    localparam int QDEPTH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] qcount;
    logic       err_underflow;

    fifo_axis_master_if #(.DLEN(DLEN)) bus ();

    fifo_axis_master #(
        .DLEN   (DLEN),
        .RD_LAT (RD_LAT),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.master),
        .o_qcount        (qcount),
        .o_err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Core model state.
    logic [DLEN-1:0] core_q [$];
    logic [DLEN-1:0] stage1 = '0;

    // Words accepted by the stream sink.
    logic [DLEN-1:0] got_q [$];

    // Per-cycle samples.
    logic            s_ren, s_tvalid, s_tready, s_push, s_err;
    logic [DLEN-1:0] s_tdata;
    logic [1:0]      s_qcount;
    logic            hold_prev = 1'b0;
    logic [DLEN-1:0] hold_data = '0;
    int              ren_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic core_write(input logic [DLEN-1:0] d);
        core_q.push_back(d);
        bus.i_fifo_rempty = 1'b0;
    endtask

    // Finish the current cycle: sample it, run the stream-side checks, pass
    // the rising edge, then advance the core model.
    task automatic next_cycle();
        @(negedge clk);
        #4;
        s_ren    = bus.o_fifo_ren;
        s_tvalid = bus.o_m_axis_tvalid;
        s_tdata  = bus.o_m_axis_tdata;
        s_tready = bus.i_m_axis_tready;
        s_qcount = qcount;
        s_err    = err_underflow;
        s_push   = dut.push;
        if (!rst) begin
            if (hold_prev) begin
                chk("axis_hold_tvalid", 32'(s_tvalid), 32'd1);
                chk("axis_hold_tdata", 32'(s_tdata), 32'(hold_data));
            end
            chk("qcount_le_depth", 32'(s_qcount <= 2'd3), 32'd1);
            chk("no_push_into_full",
                32'(s_push && !(s_tvalid && s_tready) && (s_qcount == 2'd3)), 32'd0);
            if (s_tvalid && s_tready) begin
                got_q.push_back(s_tdata);
            end
        end
        hold_prev = !rst && s_tvalid && !s_tready;
        hold_data = s_tdata;
        @(posedge clk);
        #1;
        bus.i_fifo_rdata = stage1;
        if (s_ren && core_q.size() != 0) begin
            stage1 = core_q.pop_front();
        end
        bus.i_fifo_rempty = (core_q.size() == 0);
    endtask

    initial begin
        bus.i_fifo_rdata      = '0;
        bus.i_fifo_rempty     = 1'b1;
        bus.i_fifo_runderflow = 1'b0;
        bus.i_m_axis_tready   = 1'b0;

        // ---- Reset state ----
        next_cycle();
        next_cycle();
        chk("rst_tvalid", 32'(s_tvalid), 32'd0);
        chk("rst_tdata", 32'(s_tdata), 32'd0);
        chk("rst_qcount", 32'(s_qcount), 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);
        chk("rst_ren", 32'(s_ren), 32'd0);
        rst = 1'b0;
        next_cycle();

        // ---- Full-rate streaming of 0x11..0x18 ----
        bus.i_m_axis_tready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 8; i++) core_write(8'(8'h11 + i));
        for (int k = 0; k < 14; k++) begin
            next_cycle();
            chk($sformatf("stream_ren_c%0d", k), 32'(s_ren), 32'(k < 8));
            chk($sformatf("stream_tvalid_c%0d", k), 32'(s_tvalid), 32'(k >= 3 && k <= 10));
            if (k >= 3 && k <= 10) begin
                chk($sformatf("stream_tdata_c%0d", k), 32'(s_tdata), 32'(8'h11 + k - 3));
            end
        end
        chk("stream_count", 32'(got_q.size()), 32'd8);

        // ---- Backpressure: 16 words, tready low ----
        bus.i_m_axis_tready = 1'b0;
        got_q.delete();
        ren_cnt = 0;
        for (int i = 0; i < 16; i++) core_write(8'(8'h11 + i));
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            if (s_ren) ren_cnt++;
            chk($sformatf("bp_ren_c%0d", k), 32'(s_ren), 32'(k < 3));
            chk($sformatf("bp_qcount_c%0d", k), 32'(s_qcount),
                (k < 3) ? 32'd0 : (k == 3) ? 32'd1 : (k == 4) ? 32'd2 : 32'd3);
            if (k >= 3) begin
                chk($sformatf("bp_tdata_c%0d", k), 32'(s_tdata), 32'h11);
            end
        end
        chk("bp_ren_pulses", 32'(ren_cnt), 32'd3);

        // ---- Toggling tready drains all 16 words in order ----
        for (int k = 0; k < 50; k++) begin
            bus.i_m_axis_tready = (k % 2 == 0);
            next_cycle();
        end
        chk("toggle_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            chk($sformatf("toggle_word%0d", i), 32'(got_q[i]), 32'(8'h11 + i));
        end
        chk("toggle_end_tvalid", 32'(s_tvalid), 32'd0);
        chk("toggle_end_qcount", 32'(s_qcount), 32'd0);

        // ---- Single late write into an empty core ----
        bus.i_m_axis_tready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 16; k++) begin
            if (k == 10) core_write(8'hA5);
            next_cycle();
            chk($sformatf("late_ren_c%0d", k), 32'(s_ren), 32'(k == 10));
            chk($sformatf("late_tvalid_c%0d", k), 32'(s_tvalid), 32'(k == 13));
            if (k == 13) chk("late_tdata", 32'(s_tdata), 32'hA5);
        end
        chk("late_count", 32'(got_q.size()), 32'd1);

        // ---- Reset with three words queued ----
        bus.i_m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) core_write(8'(8'h31 + i));
        for (int k = 0; k < 6; k++) next_cycle();
        chk("rq_qcount_before", 32'(s_qcount), 32'd3);
        rst = 1'b1;
        core_q.delete();
        bus.i_fifo_rempty = 1'b1;
        next_cycle();
        chk("rq_tvalid", 32'(s_tvalid), 32'd0);
        chk("rq_qcount", 32'(s_qcount), 32'd0);
        chk("rq_tdata", 32'(s_tdata), 32'd0);
        rst = 1'b0;
        bus.i_m_axis_tready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk($sformatf("rq_after_tvalid_c%0d", k), 32'(s_tvalid), 32'd0);
        end
        chk("rq_err", 32'(s_err), 32'd0);

        // ---- Reset with reads in flight: returned data must be ignored ----
        for (int i = 0; i < 4; i++) core_write(8'(8'h41 + i));
        next_cycle();
        chk("rf_ren0", 32'(s_ren), 32'd1);
        next_cycle();
        chk("rf_ren1", 32'(s_ren), 32'd1);
        rst = 1'b1;
        core_q.delete();
        bus.i_fifo_rempty = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk($sformatf("rf_tvalid_c%0d", k), 32'(s_tvalid), 32'd0);
            chk($sformatf("rf_qcount_c%0d", k), 32'(s_qcount), 32'd0);
        end
        chk("rf_emitted", 32'(got_q.size()), 32'd0);
        chk("rf_err", 32'(s_err), 32'd0);

        // ---- Sticky underflow error ----
        bus.i_fifo_runderflow = 1'b1;
        next_cycle();
        chk("uf_err_pre", 32'(s_err), 32'd0);
        bus.i_fifo_runderflow = 1'b0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            chk($sformatf("uf_err_sticky_c%0d", k), 32'(s_err), 32'd1);
        end
        rst = 1'b1;
        next_cycle();
        chk("uf_err_cleared", 32'(s_err), 32'd0);
        rst = 1'b0;
        next_cycle();
        chk("uf_err_after_rst", 32'(s_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
